// File: rtl/tick_pkg.sv
// Shared types and divisor helpers for the tick scheduler.
// Define TICK_FAST_SIM_EN to force short divisors (PDIV=10, SDIV=5).
package tick_pkg;

    typedef enum logic [1:0] {
        PAUSED    = 2'd0,
        RUNNING   = 2'd1,
        STEP_PEND = 2'd2
    } state_t;

    localparam int SIM_PDIV = 10;
    localparam int SIM_SDIV = 5;

    function automatic int calc_pdiv(input int clk_hz, input int fast_hz);
`ifdef TICK_FAST_SIM_EN
        return SIM_PDIV;
`else
        return clk_hz / fast_hz;
`endif
    endfunction

    function automatic int calc_sdiv(input int fast_hz, input int slow_hz);
`ifdef TICK_FAST_SIM_EN
        return SIM_SDIV;
`else
        return fast_hz / slow_hz;
`endif
    endfunction

    // A modulus of 2 or less still needs one bit of count.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tick_counter.sv
// Modulo-MOD counter with a registered one-cycle terminal pulse.
// The pulse is high in the cycle after the count sat at MOD-1 while enabled.
module tick_counter
    import tick_pkg::*;
#(
    parameter int MOD = 10,
    parameter int W   = cnt_width(MOD)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         terminal
);

    logic at_end;

    assign at_end = (count == W'(MOD - 1));

    // Advance and wrap on enable; flag the wrap one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            terminal <= 1'b0;
        end else begin
            terminal <= en & at_end;
            if (en) begin
                count <= at_end ? '0 : count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// Clock-enable tick generator and run/pause/single-step ALU sequencer.
// Build option TICK_FAST_SIM_EN shortens both divisors for simulation.
module tick_scheduler
    import tick_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int FAST_HZ     = 1000,
    parameter int SLOW_HZ     = 1,
    parameter int SCAN_DIGITS = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           run,
    input  logic                           step_req,
    output logic                           fast_tick,
    output logic                           slow_tick,
    output logic                           adv_tick,
    output logic [$clog2(SCAN_DIGITS)-1:0] scan_sel,
    output logic                           running
);

    // PDIV must be at least 2 so no tick can repeat on back-to-back cycles.
    localparam int PDIV = calc_pdiv(CLK_HZ, FAST_HZ);
    localparam int SDIV = calc_sdiv(FAST_HZ, SLOW_HZ);
    localparam int PW   = cnt_width(PDIV);
    localparam int SW   = cnt_width(SDIV);
    localparam int DW   = $clog2(SCAN_DIGITS);

    logic [PW-1:0] pre_count;
    logic [SW-1:0] slow_count;
    logic          fast_term;
    logic          slow_term;
    logic          step_q;
    logic          step_rise;
    logic          adv_d;
    state_t        state_q;
    state_t        state_d;

    tick_counter #(.MOD(PDIV), .W(PW)) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (1'b1),
        .count    (pre_count),
        .terminal (fast_tick)
    );

    tick_counter #(.MOD(SDIV), .W(SW)) u_slow (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (fast_term),
        .count    (slow_count),
        .terminal (slow_tick)
    );

    // Terminal conditions precede the registered ticks by one cycle.
    assign fast_term = (pre_count == PW'(PDIV - 1));
    assign slow_term = fast_term & (slow_count == SW'(SDIV - 1));
    assign step_rise = step_req & ~step_q;
    assign running   = (state_q == RUNNING);

    // Digit scan moves in lockstep with fast_tick; explicit wrap for any count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_sel <= '0;
        end else if (fast_term) begin
            if (scan_sel == DW'(SCAN_DIGITS - 1)) begin
                scan_sel <= '0;
            end else begin
                scan_sel <= scan_sel + 1'b1;
            end
        end
    end

    // State, step history and the registered advance pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= PAUSED;
            step_q   <= 1'b0;
            adv_tick <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_req;
            adv_tick <= adv_d;
        end
    end

    // Mode transitions; run always wins over a step request.
    always_comb begin
        state_d = state_q;
        adv_d   = 1'b0;
        unique case (state_q)
            PAUSED: begin
                if (run) begin
                    state_d = RUNNING;
                end else if (step_rise) begin
                    state_d = STEP_PEND;
                end
            end
            RUNNING: begin
                adv_d = slow_term;
                if (!run) begin
                    state_d = PAUSED;
                end
            end
            STEP_PEND: begin
                if (run) begin
                    state_d = RUNNING;
                end else if (fast_term) begin
                    adv_d   = 1'b1;
                    state_d = PAUSED;
                end
            end
            default: begin
                state_d = PAUSED;
            end
        endcase
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler: directed scenarios then random
// run/step traffic, compared each cycle against an arithmetic model.
module tb_tick_scheduler;

    localparam int CLK_HZ  = 100;
    localparam int FAST_HZ = 10;
    localparam int SLOW_HZ = 1;
`ifdef TICK_FAST_SIM_EN
    localparam int PDIV = 10;
    localparam int SDIV = 5;
`else
    localparam int PDIV = CLK_HZ / FAST_HZ;
    localparam int SDIV = FAST_HZ / SLOW_HZ;
`endif
    localparam int SPER = PDIV * SDIV;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       step_req;
    logic       fast_tick;
    logic       slow_tick;
    logic       adv_tick;
    logic [1:0] scan_sel;
    logic       running;
    logic       fast3;
    logic       slow3;
    logic       adv3;
    logic [1:0] scan3;
    logic       running3;

    int checks;
    int failures;

    int t;
    bit m_run;
    bit m_pend;
    bit m_prev_step;
    bit exp_adv;

    tick_scheduler #(
        .CLK_HZ(CLK_HZ), .FAST_HZ(FAST_HZ),
        .SLOW_HZ(SLOW_HZ), .SCAN_DIGITS(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .step_req(step_req),
        .fast_tick(fast_tick), .slow_tick(slow_tick),
        .adv_tick(adv_tick), .scan_sel(scan_sel), .running(running)
    );

    tick_scheduler #(
        .CLK_HZ(CLK_HZ), .FAST_HZ(FAST_HZ),
        .SLOW_HZ(SLOW_HZ), .SCAN_DIGITS(3)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .run(run), .step_req(step_req),
        .fast_tick(fast3), .slow_tick(slow3),
        .adv_tick(adv3), .scan_sel(scan3), .running(running3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0d got=%0h exp=%0h", tag, t, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_fast"}, 32'(fast_tick), 32'd0);
        chk({tag, "_slow"}, 32'(slow_tick), 32'd0);
        chk({tag, "_adv"}, 32'(adv_tick), 32'd0);
        chk({tag, "_scan"}, 32'(scan_sel), 32'd0);
        chk({tag, "_running"}, 32'(running), 32'd0);
        chk({tag, "_scan3"}, 32'(scan3), 32'd0);
    endtask

    task automatic model_reset();
        t           = 0;
        m_run       = 1'b0;
        m_pend      = 1'b0;
        m_prev_step = 1'b0;
    endtask

    // One clock: advance the model on the inputs seen at the edge, then compare.
    task automatic tick();
        bit run_v;
        bit step_v;
        bit rise;
        run_v  = run;
        step_v = step_req;
        @(posedge clk);
        t++;
        rise        = step_v & ~m_prev_step;
        m_prev_step = step_v;
        exp_adv     = 1'b0;
        if (m_run) begin
            exp_adv = (t % SPER == 0);
            if (!run_v) m_run = 1'b0;
        end else if (m_pend) begin
            if (run_v) begin
                m_run  = 1'b1;
                m_pend = 1'b0;
            end else if (t % PDIV == 0) begin
                exp_adv = 1'b1;
                m_pend  = 1'b0;
            end
        end else if (run_v) begin
            m_run = 1'b1;
        end else if (rise) begin
            m_pend = 1'b1;
        end
        #1;
        chk("fast_tick", 32'(fast_tick), 32'(t % PDIV == 0));
        chk("slow_tick", 32'(slow_tick), 32'(t % SPER == 0));
        chk("adv_tick", 32'(adv_tick), 32'(exp_adv));
        chk("scan_sel", 32'(scan_sel), 32'((t / PDIV) % 4));
        chk("scan_sel3", 32'(scan3), 32'((t / PDIV) % 3));
        chk("running", 32'(running), 32'(m_run));
    endtask

    task automatic run_to(input int n);
        while (t < n) tick();
    endtask

    task automatic reset_hold(input int n);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_async");
        repeat (n) begin
            @(posedge clk);
            #1;
            chk_zero("rst_hold");
        end
        step_req = 1'b0;
        run      = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        run      = 1'b0;
        step_req = 1'b0;
        model_reset();

        @(posedge clk);
        reset_hold(2);

        // Paused ticking, two single steps, step dropped by run, run mode.
        run_to(23);
        step_req = 1'b1;
        run_to(35);
        step_req = 1'b0;
        run_to(37);
        step_req = 1'b1;
        run_to(38);
        step_req = 1'b0;
        run_to(41);
        step_req = 1'b1;
        run_to(45);
        run = 1'b1;
        run_to(240);
        step_req = 1'b0;
        run_to(243);
        step_req = 1'b1;
        run_to(299);
        run = 1'b0;
        run_to(320);
        step_req = 1'b0;
        run_to(330);

        // Reset while a step is pending.
        reset_hold(2);
        run_to(53);
        step_req = 1'b1;
        run_to(57);
        reset_hold(3);
        run_to(60);

        // Random mode and step traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) run = ~run;
            if ($urandom_range(0, 7) == 0) step_req = ~step_req;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
